instruction_fetch: RTL

Fetch stage that owns the architectural PC register and drives the synchronous instruction memory, which has a 1-cycle read latency. It buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake. It accepts branch redirects (target PC from the PC-select logic) and flushes wrong-path instructions. It also supports a sticky halt that stops fetching and drains the buffer.

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 97 +++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage bus: imem port, redirect/halt controls, decode handshake
interface instruction_fetch_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 9
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               halted;

  modport master (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_rdata, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_rdata, redirect_valid, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, imem requester and small fetch buffer with redirect flush and sticky halt
module instruction_fetch #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 9,
  parameter int              PC_INC   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic               clk,
  input logic               reset,
  instruction_fetch_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]    r_pc;
  logic               r_inflight;
  logic [PC_W-1:0]    r_inflight_pc;
  logic [INSTR_W-1:0] r_fifo_instr [DEPTH];
  logic [PC_W-1:0]    r_fifo_pc    [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic               r_halt;
  logic               r_halted;

  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;
  logic [CW-1:0] w_count_nxt;
  logic          w_halt_nxt;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_out_valid = (r_count != '0) & ~bus.redirect_valid;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_push      = r_inflight & ~bus.redirect_valid;
  // Occupancy counts the in-flight slot so a returning response always has room.
  assign w_occ       = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue     = ~reset & ~r_halt & ~bus.halt & ~bus.redirect_valid
                     & (w_occ < (CW+1)'(DEPTH));
  assign w_count_nxt = bus.redirect_valid ? '0
                     : r_count - CW'(w_pop) + CW'(w_push);
  assign w_halt_nxt  = r_halt | bus.halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_halt        <= 1'b0;
      r_halted      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else begin
      if (bus.redirect_valid)
        r_pc <= bus.redirect_pc;
      else if (w_issue)
        r_pc <= r_pc + PC_W'(PC_INC);
      r_inflight <= w_issue;
      if (w_issue)
        r_inflight_pc <= r_pc;
      r_count  <= w_count_nxt;
      r_halt   <= w_halt_nxt;
      // Computed from next-state values so halted rises the cycle after the last pop.
      r_halted <= w_halt_nxt & (w_count_nxt == '0) & ~w_issue;
      if (bus.redirect_valid) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_pop)
          r_head <= ptr_next(r_head);
        if (w_push) begin
          r_fifo_instr[r_tail] <= bus.imem_rdata;
          r_fifo_pc[r_tail]    <= r_inflight_pc;
          r_tail               <= ptr_next(r_tail);
        end
      end
    end
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = r_fifo_instr[r_head];
  assign bus.out_pc    = r_fifo_pc[r_head];
  assign bus.halted    = r_halted;
endmodule
